// File: rtl/bus_datapath_seq.sv
// bus_datapath_seq
//   Single-bus CPU datapath with its own micro-sequencer. A register file,
//   the Y operand latch, the double-width Z result register, HI/LO and an
//   ALU all share one internal bus. A start pulse runs the whole bus
//   sequence (Y <= Rs, Z <= ALU(Y, Rt), Rd/LO/HI <= Z) and pulses done.
//
// Ports
//   clk, clr             clock, synchronous active-high reset
//   start, op, rd/rs/rt  operation request (sampled only while idle)
//   ld_en/ld_addr/ld_data  direct register load (only while idle)
//   rdbk_addr/rdbk_data  combinational register readback
//   busy                 high while a sequence is in progress
//   done, err            one-cycle completion / error pulses
//   hi, lo, z            HI, LO and {ZHI, ZLO} contents
//   bus                  current internal bus value (debug)

module bus_datapath_seq #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  localparam int RAW = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [RAW-1:0]       rd,
  input  logic [RAW-1:0]       rs,
  input  logic [RAW-1:0]       rt,
  input  logic                 ld_en,
  input  logic [RAW-1:0]       ld_addr,
  input  logic [WIDTH-1:0]     ld_data,
  input  logic [RAW-1:0]       rdbk_addr,
  output logic [WIDTH-1:0]     rdbk_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic [2*WIDTH-1:0]   z,
  output logic [WIDTH-1:0]     bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] W_AMT = (SHW+1)'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_NEG  = 4'd11;
  localparam logic [3:0] OP_NOT  = 4'd12;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [RAW-1:0]   rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] zhi_q, zhi_d, zlo_q, zlo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, err_q, err_d;
  logic             divz_q, divz_d;

  logic [WIDTH-1:0] bus_val;

  logic [WIDTH-1:0]          alu_a, alu_b, alu_hi, alu_lo;
  logic                      alu_legal, alu_divz;
  logic [SHW-1:0]            shamt;
  logic signed [2*WIDTH-1:0] a_ext, b_ext;
  logic [2*WIDTH-1:0]        prod;
  logic [WIDTH-1:0]          a_mag, b_mag, q_mag, r_mag, quot, rem;

  // The bus is driven by whichever source the current T-state selects;
  // idle and the completion cycle leave it at zero.
  always_comb begin
    bus_val = '0;
    case (state_q)
      T1:      bus_val = regs_q[rs_q];
      T2:      bus_val = regs_q[rt_q];
      T3:      bus_val = zlo_q;
      T4:      bus_val = zhi_q;
      default: bus_val = '0;
    endcase
  end

  // The ALU sees Y as operand A and the bus as operand B. Its result is only
  // captured into Z during T2, when the bus carries R[rt]. Division works on
  // magnitudes and restores signs afterwards, so the most-negative / -1 case
  // wraps to most-negative with a zero remainder instead of overflowing.
  always_comb begin
    alu_a     = y_q;
    alu_b     = bus_val;
    shamt     = alu_b[SHW-1:0];
    a_ext     = {{WIDTH{alu_a[WIDTH-1]}}, alu_a};
    b_ext     = {{WIDTH{alu_b[WIDTH-1]}}, alu_b};
    prod      = a_ext * b_ext;
    a_mag     = alu_a[WIDTH-1] ? ('0 - alu_a) : alu_a;
    b_mag     = alu_b[WIDTH-1] ? ('0 - alu_b) : alu_b;
    q_mag     = a_mag / b_mag;
    r_mag     = a_mag % b_mag;
    quot      = (alu_a[WIDTH-1] ^ alu_b[WIDTH-1]) ? ('0 - q_mag) : q_mag;
    rem       = alu_a[WIDTH-1] ? ('0 - r_mag) : r_mag;
    alu_hi    = '0;
    alu_lo    = '0;
    alu_legal = 1'b1;
    alu_divz  = 1'b0;
    case (op_q)
      OP_ADD:  alu_lo = alu_a + alu_b;
      OP_SUB:  alu_lo = alu_a - alu_b;
      OP_AND:  alu_lo = alu_a & alu_b;
      OP_OR:   alu_lo = alu_a | alu_b;
      OP_SHR:  alu_lo = alu_a >> shamt;
      OP_SHRA: alu_lo = $signed(alu_a) >>> shamt;
      OP_SHL:  alu_lo = alu_a << shamt;
      OP_ROR:  alu_lo = (alu_a >> shamt) | (alu_a << (W_AMT - {1'b0, shamt}));
      OP_ROL:  alu_lo = (alu_a << shamt) | (alu_a >> (W_AMT - {1'b0, shamt}));
      OP_MUL: begin
        alu_hi = prod[2*WIDTH-1:WIDTH];
        alu_lo = prod[WIDTH-1:0];
      end
      OP_DIV: begin
        if (alu_b == '0) begin
          alu_lo   = '1;
          alu_hi   = alu_a;
          alu_divz = 1'b1;
        end else begin
          alu_lo = quot;
          alu_hi = rem;
        end
      end
      OP_NEG:  alu_lo = '0 - alu_a;
      OP_NOT:  alu_lo = ~alu_a;
      default: alu_legal = 1'b0;
    endcase
  end

  // Sequencer next-state logic. Idle accepts either a start (which wins) or
  // a direct load. An illegal op skips straight from T2 to DONE without
  // touching Z, and a divide-by-zero is remembered from T2 so err can be
  // raised together with done after HI has been written.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    regs_d  = regs_q;
    y_d     = y_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    divz_d  = divz_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          rd_d    = rd;
          rs_d    = rs;
          rt_d    = rt;
          divz_d  = 1'b0;
          state_d = T1;
        end else if (ld_en) begin
          regs_d[ld_addr] = ld_data;
        end
      end
      T1: begin
        y_d     = bus_val;
        state_d = T2;
      end
      T2: begin
        if (!alu_legal) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          zhi_d   = alu_hi;
          zlo_d   = alu_lo;
          divz_d  = alu_divz;
          state_d = T3;
        end
      end
      T3: begin
        if (op_q == OP_MUL || op_q == OP_DIV) begin
          lo_d    = bus_val;
          state_d = T4;
        end else begin
          regs_d[rd_q] = bus_val;
          state_d      = DONE;
          done_d       = 1'b1;
        end
      end
      T4: begin
        hi_d    = bus_val;
        state_d = DONE;
        done_d  = 1'b1;
        err_d   = divz_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // All state lives here; clr wipes everything, aborting any sequence in
  // flight so no done and no write ever follows it.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      y_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      divz_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      regs_q  <= regs_d;
      y_q     <= y_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      divz_q  <= divz_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rdbk_data = regs_q[rdbk_addr];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign z         = {zhi_q, zlo_q};
  assign bus       = bus_val;

endmodule
